miriscv_fetch_unit: RTL
=======================

MIRISCV_FETCH_UNIT -- requirements
Module: miriscv_fetch_unit

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, 2..8).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-004 clk_i  in  1  core clock; all state updates on rising edge.
REQ-005 arstn_i  in  1  asynchronous active-low reset.
REQ-006 instr_req_o  out  1  instruction memory request.
REQ-007 instr_addr_o  out  32  request word address (bits [1:0] always 0).
REQ-008 instr_gnt_i  in  1  request accepted this cycle.
REQ-009 instr_rvalid_i  in  1  read data valid; responses arrive in order, at least 1 cycle after grant.
REQ-010 instr_rdata_i  in  32  fetched instruction word.
REQ-011 fetch_valid_o  out  1  buffer head holds a valid instruction for decode.
REQ-012 fetch_instr_o  out  32  head instruction, driven to the decoder instruction input.
REQ-013 fetch_pc_o  out  32  PC of the head instruction.
REQ-014 decode_ready_i  in  1  decode consumes the head this cycle when fetch_valid_o=1.
REQ-015 redirect_i  in  1  branch/jump/trap redirect; flushes everything in flight.
REQ-016 redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored and forced to 0.

Function
REQ-017 SHALL use FSM states BOOT, RUN, DRAIN; BOOT->RUN unconditionally one cycle after reset release.
REQ-018 In BOOT: instr_req_o=0.
REQ-019 In RUN: assert instr_req_o when outstanding + buffer_count < FIFO_DEPTH (credit rule); the buffer never overflows.
REQ-020 Once instr_req_o=1, hold it and instr_addr_o stable until instr_gnt_i=1, unless redirect_i=1.
REQ-021 On grant: increment fetch PC by 4 (wraps modulo 2^32) and increment outstanding count.
REQ-022 On instr_rvalid_i with discard count 0: push {instr_rdata_i, PC of that request} into the buffer and decrement outstanding.
REQ-023 Latency from instr_rvalid_i to fetch_valid_o SHALL be exactly 1 cycle; no combinational bypass.
REQ-024 fetch_valid_o=1 iff buffer non-empty; the head pops when fetch_valid_o & decode_ready_i.
REQ-025 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-026 On redirect_i, next cycle:
  - buffer empty
  - fetch PC = redirect_pc_i & ~3
  - discard count = outstanding, plus 1 if a grant occurs this same cycle
REQ-027 After a redirect, the next state SHALL be DRAIN if the new discard count > 0, else RUN.
REQ-028 In DRAIN: instr_req_o=0; each instr_rvalid_i is dropped and decrements discard and outstanding.
REQ-029 DRAIN->RUN when discard count reaches 0, including when the last stale response arrives this cycle.
REQ-030 Redirect beats a same-cycle pop and a same-cycle response; both are discarded.
REQ-031 Redirect in DRAIN SHALL update fetch PC and remain in DRAIN.
REQ-032 Outstanding and discard counters SHALL be sized to hold FIFO_DEPTH without wrap.

Reset
REQ-033 On arstn_i=0, immediately:
  - state=BOOT
  - fetch PC=BOOT_ADDR
  - all counters, buffer pointers and count = 0
  - instr_req_o=0, instr_addr_o=BOOT_ADDR
  - fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0
REQ-034 Reset mid-transaction SHALL abandon all outstanding requests; responses arriving after release are dropped because outstanding=0.

Structure
REQ-035 The FSM state typedef (fetch_state_t) and the FIFO_DEPTH default SHALL live in miriscv_pkg; XLEN from miriscv_pkg sets widths.
REQ-036 The buffer SHALL be one sub-module, miriscv_fetch_fifo (push, pop, flush, full, empty, count), which holds {instr, pc} entries.

Verification
REQ-037 Reset release, gnt always 1, rvalid 1 cycle later -> addresses 0x0,0x4,0x8 on consecutive cycles; first fetch_valid_o two cycles after first grant with fetch_pc_o=0x0.
REQ-038 decode_ready_i=0 permanently, FIFO_DEPTH=4 -> exactly 4 grants, then instr_req_o=0; buffer holds PCs 0x0..0xC in order.
REQ-039 Three requests outstanding, redirect_i=1 with redirect_pc_i=0x0000_0103 -> DRAIN; three rvalid dropped; next request address 0x0000_0100.
REQ-040 redirect_i on the same cycle as grant with one other outstanding -> discard count=2; both responses dropped; no stale PC reaches fetch_valid_o.
REQ-041 fetch PC 0xFFFF_FFFC granted -> next address 0x0000_0000.
REQ-042 arstn_i asserted while 2 requests are outstanding, then released -> instr_addr_o=BOOT_ADDR; late rvalid pulses do not raise fetch_valid_o.

Source files
------------

// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv fetch path.
//   XLEN             - architectural register and address width
//   FETCH_FIFO_DEPTH - default number of instruction buffer entries
//   fetch_state_t    - fetch FSM state encoding
//   fetch_entry_t    - one buffered instruction with its PC
package miriscv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Instruction buffer between the memory response port and decode.
// Ports:
//   clk, arstn     - clock, asynchronous active-low reset
//   push, wdata    - write one {instr, pc} entry
//   pop            - drop the head entry
//   flush          - empty the buffer (wins over push/pop)
//   rdata          - head entry (meaningless while empty)
//   full, empty    - occupancy flags
//   count          - number of valid entries
module miriscv_fetch_fifo
  import miriscv_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           push,
  input  fetch_entry_t                   wdata,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/miriscv_fetch_unit.sv
// Instruction fetch unit: issues word requests to instruction memory under a
// credit scheme, buffers in-order responses with their PCs and hands them to
// decode. Redirects flush the buffer and drop responses still in flight.
// Ports:
//   clk_i, arstn_i                    - clock, asynchronous active-low reset
//   instr_req_o, instr_addr_o         - memory request and word address
//   instr_gnt_i                       - request accepted
//   instr_rvalid_i, instr_rdata_i     - in-order read response
//   fetch_valid_o, fetch_instr_o,
//   fetch_pc_o                        - buffer head towards decode
//   decode_ready_i                    - decode consumes the head
//   redirect_i, redirect_pc_i         - change of control flow
module miriscv_fetch_unit
  import miriscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic [XLEN-1:0] fetch_pc_o,
  input  logic            decode_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XLEN-1:0] WordMask  = ~XLEN'(3);
  localparam logic [XLEN-1:0] BootAlign = BOOT_ADDR & WordMask;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // PC of the oldest response that will be kept.
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [CntW-1:0] buf_count;
  logic [CntW:0]   in_use;
  logic            buf_full;
  logic            buf_empty;
  logic            credit_ok;
  logic            grant;
  logic            resp_seen;
  logic            resp_live;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every request in flight has a buffer slot reserved, so pushes never overflow.
  assign in_use      = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign credit_ok   = (in_use < (CntW + 1)'(FIFO_DEPTH));
  assign instr_req_o = (state_q == StRun) & credit_ok;
  assign grant       = instr_req_o & instr_gnt_i;

  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign resp_seen = instr_rvalid_i & (outstanding_q != '0);
  assign resp_live = resp_seen & (discard_q == '0);
  assign resp_drop = resp_seen & (discard_q != '0);

  assign redirect_pc = redirect_pc_i & WordMask;

  // Redirect wins over a same-cycle response and pop.
  assign push = resp_live & ~redirect_i & (~buf_full | pop);
  assign pop  = fetch_valid_o & decode_ready_i & ~redirect_i;

  always_comb begin
    outstanding_d = outstanding_q + CntW'(grant) - CntW'(resp_seen);
    // After a redirect everything still in flight is stale, including a
    // request granted this very cycle.
    if (redirect_i) begin
      discard_d = outstanding_d;
    end else begin
      discard_d = discard_q - CntW'(resp_drop);
    end

    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    if (redirect_i) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
    end else begin
      if (grant) pc_d = pc_q + XLEN'(4);
      if (push)  resp_pc_d = resp_pc_q + XLEN'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      StDrain: if (discard_d == '0) state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (redirect_i) begin
      state_d = (discard_d != '0) ? StDrain : StRun;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= StBoot;
      pc_q          <= BootAlign;
      resp_pc_q     <= BootAlign;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign push_entry.instr = instr_rdata_i;
  assign push_entry.pc    = resp_pc_q;

  miriscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk_i),
    .arstn (arstn_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .flush (redirect_i),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign instr_addr_o  = pc_q;
  assign fetch_valid_o = ~buf_empty;
  // Head is forced to zero while empty so decode never sees stale storage.
  assign fetch_instr_o = fetch_valid_o ? head.instr : '0;
  assign fetch_pc_o    = fetch_valid_o ? head.pc    : '0;

endmodule
